// File: rtl/fetch_queue_if.sv
// Bundles the instruction-bus request/response and the decode-side
// valid/ready handshake of the fetch queue. The "master" side is the fetch
// queue itself (it masters the ibus and sources decode entries); "slave" is
// the environment: bus model plus decode/redirect logic.
interface fetch_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               ireq_valid;
    logic [ADDR_W-1:0]  ireq_addr;
    logic               iresp_data_ok;
    logic [INSTR_W-1:0] iresp_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_data_ok, iresp_data,
        input  redirect, redirect_pc,
        output out_valid, out_pc, out_instr,
        input  out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_data_ok, iresp_data,
        output redirect, redirect_pc,
        input  out_valid, out_pc, out_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential ibus requests, buffers up
// to DEPTH {pc, instr} pairs and hands them to decode. A redirect flushes the
// queue; a response still owed by the bus for an old request is drained and
// dropped so the bus address never changes mid-transaction.
module fetch_queue #(
    parameter int              ADDR_W   = 64,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0]  req_addr_reg, req_addr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [ADDR_W-1:0]  mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];

    logic push;
    logic pop;
    logic flush;

    assign bus.ireq_valid = (state_reg != ST_IDLE);
    assign bus.ireq_addr  = req_addr_reg;
    assign bus.out_valid  = (count_reg != '0);
    assign bus.out_pc     = mem_pc[rd_ptr_reg];
    assign bus.out_instr  = mem_instr[rd_ptr_reg];

    // Queue bookkeeping: a redirect wins over both push and pop.
    always_comb begin
        flush       = bus.redirect;
        pop         = (count_reg != '0) & bus.out_ready & ~bus.redirect;
        push        = (state_reg == ST_BUSY) & bus.iresp_data_ok & ~bus.redirect;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
            wr_ptr_next = wr_ptr_reg + PTR_W'(push);
            count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Fetch sequencing: a request is only started when the queue will have
    // room for its result, so the queue can never overflow.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                end else if (count_next < DEPTH_C) begin
                    state_next    = ST_BUSY;
                    req_addr_next = fetch_pc_reg;
                end
            end
            ST_BUSY: begin
                if (bus.iresp_data_ok) begin
                    if (bus.redirect) begin
                        fetch_pc_next = bus.redirect_pc;
                        req_addr_next = bus.redirect_pc;
                    end else begin
                        fetch_pc_next = req_addr_reg + ADDR_W'(4);
                        if (count_next < DEPTH_C) begin
                            req_addr_next = fetch_pc_reg + ADDR_W'(4);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end else if (bus.redirect) begin
                    // Bus still owes a response: keep req_addr stable and
                    // throw the response away when it arrives.
                    fetch_pc_next = bus.redirect_pc;
                    state_next    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.iresp_data_ok) begin
                    state_next = ST_BUSY;
                    if (bus.redirect) begin
                        fetch_pc_next = bus.redirect_pc;
                        req_addr_next = bus.redirect_pc;
                    end else begin
                        req_addr_next = fetch_pc_reg;
                    end
                end else if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_addr_reg <= req_addr_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Storage entries; cleared on reset so out_pc/out_instr read as zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Capture the completed fetch into this slot when it is the write target.
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_pc[gi]    <= '0;
                mem_instr[gi] <= '0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_pc[gi]    <= req_addr_reg;
                mem_instr[gi] <= bus.iresp_data;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue. A bus/redirect driver plays the ibus and
// the pipeline, keeping a transaction-level model of which fetches must reach
// decode; accepted fetches go into a scoreboard queue that a separate monitor
// drains as decode consumes entries.
module tb_fetch_queue;
    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          NCYC     = 4000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic tb_reset;

    fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) ifc ();

    fetch_queue #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (tb_reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    entry_t      sb[$];          // entries decode must still receive, in order
    bit          m_req_valid;    // a bus request should be outstanding
    logic [63:0] m_req_addr;     // its address
    bit          m_stale;        // its response belongs to a flushed stream
    logic [63:0] m_next_pc;      // next sequential fetch address
    bit          m_after_reset;  // previous edge applied reset
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares what decode sees against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                if (m_after_reset) begin
                    check("reset_out_pc", ifc.out_pc, 64'h0);
                    check("reset_out_instr", {32'h0, ifc.out_instr}, 64'h0);
                end
                check("out_valid", {63'h0, ifc.out_valid}, {63'h0, sb.size() != 0});
                if (!tb_reset && sb.size() != 0 && ifc.out_ready && !ifc.redirect) begin
                    entry_t e;
                    e = sb.pop_front();
                    check("out_pc", ifc.out_pc, e.pc);
                    check("out_instr", {32'h0, ifc.out_instr}, {32'h0, e.instr});
                end
            end
        end
    end

    // Driver plus transaction-level model of the fetch stream.
    initial begin
        bit          rst_now;
        int          ready_pct;
        logic [63:0] rpc;

        tb_reset          = 1'b1;
        ifc.iresp_data_ok = 1'b0;
        ifc.iresp_data    = '0;
        ifc.redirect      = 1'b0;
        ifc.redirect_pc   = '0;
        ifc.out_ready     = 1'b0;
        m_req_valid       = 1'b0;
        m_req_addr        = RESET_PC;
        m_stale           = 1'b0;
        m_next_pc         = RESET_PC;
        m_after_reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < NCYC; i++) begin
            // Drive this cycle's inputs
            rst_now   = (i > 20) && ($urandom_range(0, 149) == 0);
            ready_pct = ((i / 150) % 3 == 0) ? 5 : (((i / 150) % 3 == 1) ? 95 : 50);
            case ($urandom_range(0, 3))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                default: rpc = RESET_PC + 64'($urandom_range(0, 1023)) * 64'd4;
            endcase
            tb_reset          = rst_now;
            ifc.redirect      = ($urandom_range(0, 11) == 0);
            ifc.redirect_pc   = rpc;
            ifc.out_ready     = ($urandom_range(0, 99) < ready_pct);
            ifc.iresp_data_ok = m_req_valid && ($urandom_range(0, 99) < 60);
            ifc.iresp_data    = $urandom;
            #1;
            check("ireq_valid", {63'h0, ifc.ireq_valid}, {63'h0, m_req_valid});
            if (m_req_valid) check("ireq_addr", ifc.ireq_addr, m_req_addr);
            #2;
            // Advance the model past the coming edge (monitor has already popped)
            if (rst_now) begin
                sb.delete();
                m_req_valid = 1'b0;
                m_stale     = 1'b0;
                m_next_pc   = RESET_PC;
            end else begin
                if (ifc.redirect) sb.delete();
                if (!m_req_valid) begin
                    if (ifc.redirect) begin
                        m_next_pc = ifc.redirect_pc;
                    end else if (sb.size() < DEPTH) begin
                        m_req_valid = 1'b1;
                        m_req_addr  = m_next_pc;
                        m_stale     = 1'b0;
                    end
                end else if (ifc.iresp_data_ok) begin
                    if (m_stale || ifc.redirect) begin
                        if (ifc.redirect) m_next_pc = ifc.redirect_pc;
                        m_req_addr = m_next_pc;
                        m_stale    = 1'b0;
                    end else begin
                        sb.push_back('{pc: m_req_addr, instr: ifc.iresp_data});
                        m_next_pc = m_req_addr + 64'd4;
                        if (sb.size() < DEPTH) m_req_addr = m_next_pc;
                        else m_req_valid = 1'b0;
                    end
                end else if (ifc.redirect) begin
                    m_stale   = 1'b1;
                    m_next_pc = ifc.redirect_pc;
                end
            end
            m_after_reset = rst_now;
            @(posedge clk);
            #1;
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
